// File: rtl/round_ctrl_if.sv
// Bundle of the sequencer's button, sensor and status signals.
// The master side drives buttons and sensors; the slave side is round_ctrl.
interface round_ctrl_if;
  logic       start_pulse;
  logic       round_pulse;
  logic [7:0] ball;
  logic [2:0] state;
  logic [3:0] ball_num;
  logic [2:0] selected_group;
  logic [7:0] group_mask;
  logic       hit_valid;
  logic [2:0] hit_idx;
  logic       hit_bonus;
  logic       game_over;

  modport master (
    output start_pulse, round_pulse, ball,
    input  state, ball_num, selected_group, group_mask,
    input  hit_valid, hit_idx, hit_bonus, game_over
  );

  modport slave (
    input  start_pulse, round_pulse, ball,
    output state, ball_num, selected_group, group_mask,
    output hit_valid, hit_idx, hit_bonus, game_over
  );
endinterface

// File: rtl/round_ctrl.sv
// Pinball round sequencer: round FSM, ball count, bonus-group rotation and
// reduction of simultaneous hole hits to a single hit event per ball.
module round_ctrl #(
  parameter int unsigned BALLS       = 5,
  parameter int unsigned SETTLE_CYC  = 2000000,
  parameter int unsigned GROUP_CYC   = 5000000,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input logic         clk,
  input logic         rst,
  round_ctrl_if.slave bus
);

  localparam int unsigned TimerW = 30;

  typedef enum logic [2:0] {
    StReset = 3'd0,
    StWait  = 3'd1,
    StStart = 3'd2,
    StGet   = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          ball_num_q, ball_num_d;
  logic [2:0]          group_q, group_d;
  logic [7:0]          mask_q, mask_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [TimerW-1:0]   gcnt_q, gcnt_d;
  logic                hit_valid_q, hit_valid_d;
  logic [2:0]          hit_idx_q, hit_idx_d;
  logic                hit_bonus_q, hit_bonus_d;
  logic                game_over_q, game_over_d;
  logic [2:0]          low_idx;
  logic [3:0]          ball_num_dec;

  function automatic logic [7:0] mask_of(logic [2:0] g);
    logic [2:0] g_opp;
    g_opp = g + 3'd4;
    return (8'd1 << g) | (8'd1 << g_opp);
  endfunction

  // Lowest set bit wins when several holes fire together.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.ball[i]) low_idx = 3'(i);
    end
  end

  assign ball_num_dec = (ball_num_q == 4'd0) ? 4'd0 : ball_num_q - 4'd1;

  always_comb begin
    state_d     = state_q;
    ball_num_d  = ball_num_q;
    hit_valid_d = 1'b0;
    hit_idx_d   = hit_idx_q;
    hit_bonus_d = hit_bonus_q;
    group_d     = group_q;
    gcnt_d      = gcnt_q;

    unique case (state_q)
      StReset: begin
        if (bus.start_pulse) begin
          state_d    = StWait;
          ball_num_d = 4'(BALLS);
        end
      end
      StWait: begin
        if (bus.round_pulse) state_d = StStart;
      end
      StStart: begin
        if (bus.ball != 8'd0) begin
          state_d     = StGet;
          hit_valid_d = 1'b1;
          hit_idx_d   = low_idx;
          hit_bonus_d = mask_q[low_idx];
          ball_num_d  = ball_num_dec;
        end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
          state_d    = StGet;
          ball_num_d = ball_num_dec;
        end
      end
      StGet: begin
        if (timer_q == TimerW'(SETTLE_CYC - 1)) begin
          state_d = (ball_num_q == 4'd0) ? StOver : StWait;
        end
      end
      StOver: begin
        if (bus.start_pulse) state_d = StReset;
      end
      default: state_d = StReset;
    endcase

    // Group only rotates while no round is in play, so the bonus is fixed per round.
    if (state_q == StReset || state_q == StWait) begin
      if (gcnt_q == TimerW'(GROUP_CYC - 1)) begin
        gcnt_d  = '0;
        group_d = group_q + 3'd1;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end

    if (state_d != state_q)  timer_d = '0;
    else if (&timer_q)       timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;

    mask_d      = mask_of(group_d);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReset;
      ball_num_q  <= 4'd0;
      group_q     <= 3'd0;
      mask_q      <= mask_of(3'd0);
      timer_q     <= '0;
      gcnt_q      <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= 3'd0;
      hit_bonus_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_num_q  <= ball_num_d;
      group_q     <= group_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      gcnt_q      <= gcnt_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      hit_bonus_q <= hit_bonus_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.ball_num       = ball_num_q;
  assign bus.selected_group = group_q;
  assign bus.group_mask     = mask_q;
  assign bus.hit_valid      = hit_valid_q;
  assign bus.hit_idx        = hit_idx_q;
  assign bus.hit_bonus      = hit_bonus_q;
  assign bus.game_over      = game_over_q;

endmodule
